timer_dev: RTL



---
 rtl/timer_pkg.sv | 35 +++
 rtl/timer_if.sv | 11 +
 rtl/timer_dev.sv | 83 ++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, CTRL field positions and the store byte-lane merge.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // Byte i of the result comes from wd when be[i] is set, else from old.
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/timer_if.sv
// Data-bus port of the timer: word offset, byte enables, write/read data, irq.
interface timer_if;
  logic [1:0]  addr;
  logic [3:0]  byteen;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  modport master (output addr, byteen, wd, input rd, irq);
  modport slave  (input addr, byteen, wd, output rd, irq);
endinterface

// File: rtl/timer_dev.sv
// Countdown timer: CTRL/PRESET/COUNT register file, IDLE/LOAD/CNT/INT FSM,
// level irq from a pending flag gated by the CTRL interrupt mask.
module timer_dev
  import timer_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int CTRL_W = 4
) (
  input  logic   clk,
  input  logic   reset,
  timer_if.slave bus
);

  logic [CTRL_W-1:0] ctrl, ctrl_new;
  logic [CNT_W-1:0]  preset, preset_new, count;
  logic              pend;
  state_e            state;
  logic              wr_ctrl, wr_preset;

  always_comb begin
    wr_ctrl    = (bus.byteen != 4'b0) && (bus.addr == OFS_CTRL);
    wr_preset  = (bus.byteen != 4'b0) && (bus.addr == OFS_PRESET);
    ctrl_new   = CTRL_W'(byte_merge(32'(ctrl), bus.wd, bus.byteen));
    preset_new = CNT_W'(byte_merge(32'(preset), bus.wd, bus.byteen));
  end

  always_comb begin
    case (bus.addr)
      OFS_CTRL:   bus.rd = 32'(ctrl);
      OFS_PRESET: bus.rd = 32'(preset);
      OFS_COUNT:  bus.rd = 32'(count);
      default:    bus.rd = '0;
    endcase
  end

  assign bus.irq = pend & ctrl[CTRL_IM];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      pend   <= 1'b0;
      state  <= ST_IDLE;
    end else begin
      if (wr_ctrl)   ctrl   <= ctrl_new;
      if (wr_preset) preset <= preset_new;
      // Clear first so that a set from the FSM below on the same edge wins.
      if (wr_ctrl || wr_preset) pend <= 1'b0;

      case (state)
        ST_IDLE: if (ctrl[CTRL_EN]) state <= ST_LOAD;
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl[CTRL_EN]) begin
            state <= ST_IDLE;
          end else if (count <= CNT_W'(1)) begin
            count <= '0;
            pend  <= 1'b1;
            state <= ST_INT;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        ST_INT: begin
          if (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO) begin
            pend  <= 1'b0;
            state <= ST_LOAD;
          end else begin
            // A bus write to CTRL on this edge takes precedence over the EN clear.
            if (!wr_ctrl) ctrl[CTRL_EN] <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
